// File: rtl/simon_input_checker_if.sv
// ============================================================================
// Module : simon_input_checker_if
// Brief  : Round-control, button and sequence-memory signals of the checker.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface simon_input_checker_if;
  logic       start;
  logic [3:0] level;
  logic [3:0] btn_n;
  logic [1:0] expected_led;
  logic [3:0] count;
  logic       busy;
  logic       done;
  logic       pass;
  logic       fail;
  logic [3:0] led_echo;

  modport master (
    output start, level, btn_n, expected_led,
    input  count, busy, done, pass, fail, led_echo
  );

  modport slave (
    input  start, level, btn_n, expected_led,
    output count, busy, done, pass, fail, led_echo
  );
endinterface

`default_nettype wire

// File: rtl/simon_input_checker.sv
// ============================================================================
// Module : simon_input_checker
// Brief  : Debounces the player's buttons and checks presses against the
//          stored sequence; optional press timeout via SIMON_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module simon_input_checker #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
  parameter logic [27:0] TIMEOUT_CYCLES  = 28'd250000000
) (
  input  wire logic             clk,
  input  wire logic             reset,
  simon_input_checker_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_WAIT_PRESS   = 3'd1,
    S_WAIT_RELEASE = 3'd2,
    S_PASS         = 3'd3,
    S_FAIL         = 3'd4
  } state_t;

  if (DEBOUNCE_CYCLES < 20'd2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (TIMEOUT_CYCLES < 28'd2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  logic [3:0]  r_sync1;
  logic [3:0]  r_sync2;
  logic [3:0]  w_raw;
  logic [3:0]  r_db;
  logic [3:0]  w_db_next;
  logic [3:0]  w_rise;
  logic [19:0] r_db_cnt [4];
  logic        r_press;

  // Buttons are active-low, so the synchroniser resets to "released".
  always_comb begin
    w_raw     = ~r_sync2;
    w_db_next = r_db;
    for (int i = 0; i < 4; i++) begin
      if ((w_raw[i] != r_db[i]) && (r_db_cnt[i] == DEBOUNCE_CYCLES - 20'd1)) begin
        w_db_next[i] = w_raw[i];
      end
    end
    w_rise = w_db_next & ~r_db;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 4'hF;
      r_sync2 <= 4'hF;
      r_db    <= 4'h0;
      r_press <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_db_cnt[i] <= 20'd0;
      end
    end else begin
      r_sync1 <= bus.btn_n;
      r_sync2 <= r_sync1;
      r_db    <= w_db_next;
      r_press <= |w_rise;
      for (int i = 0; i < 4; i++) begin
        if ((w_raw[i] == r_db[i]) || (r_db_cnt[i] == DEBOUNCE_CYCLES - 20'd1)) begin
          r_db_cnt[i] <= 20'd0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 20'd1;
        end
      end
    end
  end

  logic [3:0] w_idx;
  logic       w_single;
  logic       w_match;

  always_comb begin
    w_idx = 4'd0;
    case (r_db)
      4'b0010: w_idx = 4'd1;
      4'b0100: w_idx = 4'd2;
      4'b1000: w_idx = 4'd3;
      default: w_idx = 4'd0;
    endcase
    w_single = $onehot(r_db);
    w_match  = w_single && (w_idx == {2'b00, bus.expected_led});
  end

  state_t     r_state;
  logic [3:0] r_level;
  logic [3:0] r_count;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic       r_fail;
`ifdef SIMON_TIMEOUT_EN
  logic [27:0] r_idle;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_level <= 4'd0;
      r_count <= 4'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_fail  <= 1'b0;
`ifdef SIMON_TIMEOUT_EN
      r_idle  <= 28'd0;
`endif
    end else begin
      r_done <= 1'b0;
      if (bus.start) begin
        // A start anywhere restarts the round; a done owed from PASS/FAIL still fires.
        r_done  <= (r_state == S_PASS) || (r_state == S_FAIL);
        r_level <= bus.level;
        r_count <= 4'd0;
        r_pass  <= 1'b0;
        r_fail  <= 1'b0;
        r_busy  <= 1'b1;
        r_state <= (bus.level == 4'd0) ? S_PASS : S_WAIT_PRESS;
`ifdef SIMON_TIMEOUT_EN
        r_idle  <= 28'd0;
`endif
      end else begin
        case (r_state)
          S_IDLE: begin
            r_busy <= 1'b0;
          end
          S_WAIT_PRESS: begin
            if (r_press) begin
              r_state <= w_match ? S_WAIT_RELEASE : S_FAIL;
`ifdef SIMON_TIMEOUT_EN
              r_idle  <= 28'd0;
            end else if (r_idle == TIMEOUT_CYCLES - 28'd1) begin
              r_state <= S_FAIL;
            end else begin
              r_idle  <= r_idle + 28'd1;
`endif
            end
          end
          S_WAIT_RELEASE: begin
            if (r_press) begin
              r_state <= S_FAIL;
            end else if (r_db == 4'h0) begin
              if (r_count == r_level - 4'd1) begin
                r_state <= S_PASS;
              end else begin
                r_count <= r_count + 4'd1;
                r_state <= S_WAIT_PRESS;
`ifdef SIMON_TIMEOUT_EN
                r_idle  <= 28'd0;
`endif
              end
            end
          end
          S_PASS: begin
            r_pass  <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          S_FAIL: begin
            r_fail  <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.count    = r_count;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.pass     = r_pass;
  assign bus.fail     = r_fail;
  assign bus.led_echo = r_db;

endmodule

`default_nettype wire
